// File: rtl/audio_in_note_detector.sv
// rtl/audio_in_note_detector.sv - left-channel pitch detector producing a one-hot piano note
//
// Pops samples from the Audio_Controller input FIFO, tracks rising zero
// crossings of the left channel with hysteresis, measures the period between
// crossings and maps it onto the 10-note switch code (bit0=C4 .. bit9=E5).
//
// Ports:
//   Clk                    system clock
//   resetn                 asynchronous active-low reset
//   enable                 gates new pops; sampled only while idle
//   audio_in_available     controller holds at least one input sample
//   left_channel_audio_in  signed left sample, valid while available
//   read_audio_in          one-cycle pop strobe
//   sample_valid           one-cycle pulse when a sample is processed
//   period                 last measured period in samples
//   note                   one-hot detected note, 0 = none
//   note_valid             one-cycle pulse when note changes value
module audio_in_note_detector #(
  parameter logic signed [31:0] THRESH  = 32'sd500_000,
  parameter int                 TIMEOUT = 400,
  parameter logic [9:0]         PMAX    = 10'd1023
) (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  output logic        read_audio_in,
  output logic        sample_valid,
  output logic [9:0]  period,
  output logic [9:0]  note,
  output logic        note_valid
);

  localparam int             SW      = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]  SIL_MAX = SW'(TIMEOUT);

  typedef enum logic [1:0] {ST_WAIT, ST_READ, ST_PROC} state_t;

  state_t             state, state_n;
  logic signed [31:0] sample_q;
  logic [9:0]         cnt, cnt_n, cnt_inc;
  logic [9:0]         period_n, note_n, prev_note, prev_note_n, cls;
  logic [SW-1:0]      silence, silence_n, sil_inc;
  logic               armed, armed_n;
  logic               pol_pos, pol_pos_n;
  logic               below, above, rising, timeout;

  // Period ranges at 48 kHz, inclusive on both ends.
  function automatic logic [9:0] classify(input logic [9:0] p);
    if      (p >= 10'd174 && p <= 10'd194) return 10'b00_0000_0001;
    else if (p >= 10'd155 && p <= 10'd173) return 10'b00_0000_0010;
    else if (p >= 10'd142 && p <= 10'd154) return 10'b00_0000_0100;
    else if (p >= 10'd130 && p <= 10'd141) return 10'b00_0000_1000;
    else if (p >= 10'd116 && p <= 10'd129) return 10'b00_0001_0000;
    else if (p >= 10'd104 && p <= 10'd115) return 10'b00_0010_0000;
    else if (p >= 10'd95  && p <= 10'd103) return 10'b00_0100_0000;
    else if (p >= 10'd87  && p <= 10'd94)  return 10'b00_1000_0000;
    else if (p >= 10'd78  && p <= 10'd86)  return 10'b01_0000_0000;
    else if (p >= 10'd69  && p <= 10'd77)  return 10'b10_0000_0000;
    else                                   return 10'b00_0000_0000;
  endfunction

  always_comb begin
    below   = sample_q < -THRESH;
    above   = sample_q > THRESH;
    rising  = above && !pol_pos;
    // cnt_inc doubles as the new period: the crossing sample closes the cycle.
    cnt_inc = (cnt == PMAX) ? PMAX : cnt + 10'd1;
    sil_inc = (silence == SIL_MAX) ? SIL_MAX : silence + SW'(1);
    timeout = (sil_inc == SIL_MAX);
    cls     = classify(cnt_inc);

    state_n       = state;
    cnt_n         = cnt;
    silence_n     = silence;
    armed_n       = armed;
    pol_pos_n     = pol_pos;
    period_n      = period;
    note_n        = note;
    prev_note_n   = prev_note;
    read_audio_in = 1'b0;
    sample_valid  = 1'b0;
    note_valid    = 1'b0;

    case (state)
      ST_WAIT: if (enable && audio_in_available) state_n = ST_READ;
      ST_READ: begin
        read_audio_in = 1'b1;
        state_n       = ST_PROC;
      end
      ST_PROC: begin
        sample_valid = 1'b1;
        state_n      = ST_WAIT;
        if (below)       pol_pos_n = 1'b0;
        else if (rising) pol_pos_n = 1'b1;

        if (rising) begin
          // A crossing always takes priority over a coincident timeout.
          cnt_n     = '0;
          silence_n = '0;
          if (!armed) begin
            armed_n = 1'b1;
          end else begin
            period_n    = cnt_inc;
            prev_note_n = cls;
            if (cls == prev_note) note_n = cls;
          end
        end else begin
          cnt_n     = cnt_inc;
          silence_n = sil_inc;
          if (timeout) begin
            note_n      = '0;
            armed_n     = 1'b0;
            prev_note_n = '0;
            pol_pos_n   = 1'b0;
          end
        end
        note_valid = (note_n != note);
      end
      default: state_n = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_WAIT;
      sample_q  <= '0;
      cnt       <= '0;
      silence   <= '0;
      armed     <= 1'b0;
      pol_pos   <= 1'b0;
      period    <= '0;
      note      <= '0;
      prev_note <= '0;
    end else begin
      state     <= state_n;
      if (state == ST_READ) sample_q <= left_channel_audio_in;
      cnt       <= cnt_n;
      silence   <= silence_n;
      armed     <= armed_n;
      pol_pos   <= pol_pos_n;
      period    <= period_n;
      note      <= note_n;
      prev_note <= prev_note_n;
    end
  end

endmodule

// File: tb/tb_audio_in_note_detector.sv
// tb/tb_audio_in_note_detector.sv - randomized and directed bench for audio_in_note_detector
module tb_audio_in_note_detector;

  localparam int THR = 500000;
  localparam int TMO = 400;
  localparam int PMX = 1023;

  logic        Clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        audio_in_available = 1'b0;
  logic [31:0] left_channel_audio_in = '0;
  logic        read_audio_in, sample_valid, note_valid;
  logic [9:0]  period, note;

  audio_in_note_detector dut (
    .Clk                   (Clk),
    .resetn                (resetn),
    .enable                (enable),
    .audio_in_available    (audio_in_available),
    .left_channel_audio_in (left_channel_audio_in),
    .read_audio_in         (read_audio_in),
    .sample_valid          (sample_valid),
    .period                (period),
    .note                  (note),
    .note_valid            (note_valid)
  );

  always #10 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int nv_count = 0;
  bit in_reset = 1'b0;
  bit prev_rd = 1'b0;
  int q[$];

  int lo[10] = '{174, 155, 142, 130, 116, 104, 95, 87, 78, 69};
  int hi[10] = '{194, 173, 154, 141, 129, 115, 103, 94, 86, 77};

  // Reference state, in plain integers.
  bit m_neg;
  bit m_armed;
  int m_cnt, m_sil, m_prev, m_note, m_period;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_class(input int p);
    for (int i = 0; i < 10; i++)
      if (p >= lo[i] && p <= hi[i]) return 1 << i;
    return 0;
  endfunction

  task automatic m_reset();
    m_neg = 1'b1; m_armed = 1'b0;
    m_cnt = 0; m_sil = 0; m_prev = 0; m_note = 0; m_period = 0;
  endtask

  task automatic m_step(input int s, output int nv);
    bit rising = 1'b0;
    int c;
    nv = 0;
    if (s < -THR) m_neg = 1'b1;
    else if (s > THR && m_neg) begin rising = 1'b1; m_neg = 1'b0; end
    if (rising) begin
      if (m_armed) begin
        m_period = (m_cnt + 1 > PMX) ? PMX : m_cnt + 1;
        c = m_class(m_period);
        if (c == m_prev && c != m_note) begin m_note = c; nv = 1; end
        m_prev = c;
      end else begin
        m_armed = 1'b1;
      end
      m_cnt = 0;
      m_sil = 0;
    end else begin
      m_cnt = (m_cnt + 1 > PMX) ? PMX : m_cnt + 1;
      m_sil = (m_sil + 1 > TMO) ? TMO : m_sil + 1;
      if (m_sil == TMO) begin
        if (m_note != 0) nv = 1;
        m_note = 0; m_armed = 1'b0; m_prev = 0; m_neg = 1'b1;
      end
    end
  endtask

  // Per-cycle comparison against the reference.
  always @(negedge Clk) begin
    int s, env;
    if (resetn && !in_reset) begin
      chk("period", period, m_period);
      chk("note", note, m_note);
      chk("sample_valid", sample_valid, q.size());
      chk("read_back_to_back", read_audio_in & prev_rd, 0);
      if (sample_valid && q.size() > 0) begin
        s = q.pop_front();
        m_step(s, env);
        chk("note_valid", note_valid, env);
        if (note_valid) nv_count++;
      end else begin
        chk("note_valid_idle", note_valid, 0);
      end
      if (read_audio_in) q.push_back(int'($signed(left_channel_audio_in)));
      prev_rd = read_audio_in;
    end
  end

  task automatic give(input int s);
    int n = 0;
    left_channel_audio_in = s;
    audio_in_available = 1'b1;
    @(negedge Clk);
    while (!read_audio_in && n < 50) begin @(negedge Clk); n++; end
    chk("pop_seen", read_audio_in, 1);
    @(posedge Clk); #1;
    audio_in_available = 1'b0;
  endtask

  task automatic gap();
    int k = $urandom_range(1, 6);
    enable = $urandom_range(0, 1);
    audio_in_available = !enable;
    repeat (k) @(posedge Clk);
    #1;
    enable = 1'b1;
    audio_in_available = 1'b0;
  endtask

  task automatic tone(input int p, input int cycles, input int amp, input int noise, input bit gaps);
    int j;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < p - p / 2; i++) begin
        j = (noise > 0) ? $urandom_range(0, 2 * noise) - noise : 0;
        if (gaps && $urandom_range(0, 7) == 0) gap();
        give(-amp + j);
      end
      for (int i = 0; i < p / 2; i++) begin
        j = (noise > 0) ? $urandom_range(0, 2 * noise) - noise : 0;
        if (gaps && $urandom_range(0, 7) == 0) gap();
        give(amp + j);
      end
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    int cnt, n, nv0;
    m_reset();
    #5;
    chk("reset_read", read_audio_in, 0);
    chk("reset_sample_valid", sample_valid, 0);
    chk("reset_period", period, 0);
    chk("reset_note", note, 0);
    chk("reset_note_valid", note_valid, 0);
    #10 resetn = 1'b1;
    @(posedge Clk); #1;

    // Handshake rate with enable high, then no pops with enable low.
    enable = 1'b1;
    audio_in_available = 1'b1;
    cnt = 0;
    repeat (30) begin @(negedge Clk); if (read_audio_in) cnt++; end
    chk("handshake_pops_enabled", cnt, 10);
    @(posedge Clk); #1;
    audio_in_available = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    enable = 1'b0;
    audio_in_available = 1'b1;
    cnt = 0;
    repeat (30) begin @(negedge Clk); if (read_audio_in) cnt++; end
    chk("handshake_pops_disabled", cnt, 0);
    @(posedge Clk); #1;
    audio_in_available = 1'b0;
    enable = 1'b1;

    // A4 at 109 samples per period.
    nv0 = nv_count;
    tone(109, 2, 1000000, 0, 1'b0);
    settle();
    chk("a4_period_2nd_crossing", period, 109);
    chk("a4_note_before_confirm", note, 0);
    tone(109, 1, 1000000, 0, 1'b0);
    settle();
    chk("a4_note", note, 32);
    chk("a4_note_valid_pulses", nv_count - nv0, 1);

    // Change to C4 (184 samples).
    tone(184, 2, 1000000, 0, 1'b0);
    settle();
    chk("c4_first_period", period, 184);
    chk("c4_note_held", note, 32);
    nv0 = nv_count;
    tone(184, 1, 1000000, 0, 1'b0);
    settle();
    chk("c4_note", note, 1);
    chk("c4_note_valid_pulses", nv_count - nv0, 1);

    // C5, ending exactly on the confirming crossing, then silence to timeout.
    tone(92, 2, 1000000, 0, 1'b0);
    repeat (46) give(-1000000);
    give(1000000);
    settle();
    chk("c5_note", note, 128);
    chk("c5_period", period, 92);
    repeat (TMO - 1) give(0);
    settle();
    chk("timeout_not_yet", note, 128);
    nv0 = nv_count;
    give(0);
    settle();
    chk("timeout_note_cleared", note, 0);
    chk("timeout_note_valid_pulses", nv_count - nv0, 1);

    // Sub-threshold noise produces no crossings.
    for (int i = 0; i < 50; i++) give((i % 2 == 0) ? 400000 : -400000);
    settle();
    chk("hyst_period", period, 92);
    chk("hyst_note", note, 0);

    // After timeout a tone needs three crossings again.
    tone(92, 2, 1000000, 0, 1'b0);
    settle();
    chk("rearm_note_pending", note, 0);
    tone(92, 1, 1000000, 0, 1'b0);
    settle();
    chk("rearm_note", note, 128);

    // Asynchronous reset while READ is active.
    left_channel_audio_in = 32'd77;
    audio_in_available = 1'b1;
    n = 0;
    @(negedge Clk);
    while (!read_audio_in && n < 50) begin @(negedge Clk); n++; end
    chk("reset_midop_in_read", read_audio_in, 1);
    #2;
    in_reset = 1'b1;
    resetn = 1'b0;
    #1;
    chk("reset_midop_read", read_audio_in, 0);
    chk("reset_midop_note", note, 0);
    chk("reset_midop_period", period, 0);
    audio_in_available = 1'b0;
    m_reset();
    q.delete();
    prev_rd = 1'b0;
    #4 resetn = 1'b1;
    @(posedge Clk); #1;
    in_reset = 1'b0;
    tone(92, 3, 1000000, 0, 1'b0);
    settle();
    chk("resume_note", note, 128);

    // Threshold boundaries: equality with the threshold is not beyond it.
    give(-THR); give(THR); give(-THR - 1); give(THR); give(THR + 1);
    give(-THR - 1); give(THR + 1);

    // Randomized tones with noise, gaps and enable toggles.
    for (int t = 0; t < 8; t++)
      tone($urandom_range(60, 200), $urandom_range(1, 4),
           $urandom_range(900000, 2000000), 300000, 1'b1);
    for (int i = 0; i < 40; i++) give($urandom_range(0, 800000) - 400000);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
